// File: rtl/aes_128_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock, on-the-fly key expansion.
// Optional macro AES_LAST_KEY_OUT_EN exports round key 10 on port last_key.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] acc, xx;
    acc = 8'h00;
    xx  = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) acc = acc ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] p, r;
  // Multiplicative inverse as a^254 (maps 0 to 0), then the FIPS-197 affine transform.
  always_comb begin
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    y = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  end
endmodule

module aes_128_encrypt_iter #(
  parameter int NR      = 10,
  parameter bit OUT_REG = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
`ifdef AES_LAST_KEY_OUT_EN
  ,
  output logic [127:0] last_key
`endif
);
  if (NR != 10) begin : g_bad_nr
    $error("aes_128_encrypt_iter: NR must be 10");
  end

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} st_t;

  st_t          fsm;
  logic [127:0] state, rk, sb, sr, mc, nk, fin;
  logic [7:0]   rcon;
  logic [3:0]   round;
  logic [31:0]  rot, sw;
  logic         done_entry;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar k = 0; k < 16; k++) begin : g_sb
    aes_sbox u_sb (.a(state[127-8*k -: 8]), .y(sb[127-8*k -: 8]));
  end

  assign rot = {rk[23:0], rk[31:24]};
  for (genvar k = 0; k < 4; k++) begin : g_ksb
    aes_sbox u_ksb (.a(rot[31-8*k -: 8]), .y(sw[31-8*k -: 8]));
  end

  // Byte s(r,c) lives at index 4c+r counted from the MSB.
  always_comb begin
    sr = '0;
    mc = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = sr[127-32*c -: 8];
      a1 = sr[119-32*c -: 8];
      a2 = sr[111-32*c -: 8];
      a3 = sr[103-32*c -: 8];
      mc[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      mc[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      mc[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      mc[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
  end

  always_comb begin
    nk[127:96] = rk[127:96] ^ sw ^ {rcon, 24'h0};
    nk[95:64]  = rk[95:64] ^ nk[127:96];
    nk[63:32]  = rk[63:32] ^ nk[95:64];
    nk[31:0]   = rk[31:0]  ^ nk[63:32];
  end

  assign fin        = sr ^ nk;
  assign done_entry = (fsm == S_ROUND) && (round == 4'(NR));

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm       <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      round     <= '0;
      rcon      <= 8'h01;
      state     <= '0;
      rk        <= '0;
    end else begin
      case (fsm)
        S_IDLE: if (in_valid) begin
          state    <= in_data ^ in_key;
          rk       <= in_key;
          rcon     <= 8'h01;
          round    <= 4'd1;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          fsm      <= S_ROUND;
        end
        S_ROUND: begin
          rk    <= nk;
          rcon  <= xt(rcon);
          round <= round + 4'd1;
          if (done_entry) begin
            state     <= fin;
            out_valid <= 1'b1;
            fsm       <= S_DONE;
          end else begin
            state <= mc ^ nk;
          end
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          fsm       <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  if (OUT_REG) begin : g_oreg
    logic [127:0] out_q;
    always_ff @(posedge clk) begin
      if (reset) out_q <= '0;
      else if (done_entry) out_q <= fin;
    end
    assign out_data = out_q;
  end else begin : g_ostate
    assign out_data = state;
  end

`ifdef AES_LAST_KEY_OUT_EN
  always_ff @(posedge clk) begin
    if (reset) last_key <= '0;
    else if (done_entry) last_key <= nk;
  end
`endif
endmodule

// File: tb/tb_aes_128_encrypt_iter.sv
// Directed bench for aes_128_encrypt_iter: FIPS-197 / SP800-38A vectors, stalls, ignored input, mid-run reset.
module tb_aes_128_encrypt_iter;
  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, in_key, out_data;
`ifdef AES_LAST_KEY_OUT_EN
  logic [127:0] last_key;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int prev_acc = -1;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] L1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] L2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_128_encrypt_iter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
`ifdef AES_LAST_KEY_OUT_EN
    , .last_key(last_key)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One block: accept, check latency/result, hold out_ready low for `stall` cycles, then drain.
  task automatic run(input string tag, input logic [127:0] key, input logic [127:0] pt,
                     input logic [127:0] exp, input logic [127:0] lk, input bit has_lk, input int stall);
    int n;
    in_key = key; in_data = pt; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk({tag, "_ready_to"}, 132'(n < 50), 132'(1));
    tick();
    in_valid = 1'b0;
    if (prev_acc >= 0) chk({tag, "_spacing"}, 132'(cyc - prev_acc >= 12), 132'(1));
    prev_acc = cyc;
    n = 0;
    while (!out_valid && n < 30) begin tick(); n++; end
    chk({tag, "_latency"}, 132'(n), 132'(10));
    chk({tag, "_data"}, {4'h0, out_data}, {4'h0, exp});
`ifdef AES_LAST_KEY_OUT_EN
    if (has_lk) chk({tag, "_lastkey"}, {4'h0, last_key}, {4'h0, lk});
`else
    if (has_lk && lk == 128'h0) chk({tag, "_nolk"}, 132'(1), 132'(0));
`endif
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_stall"}, {1'b0, out_valid, in_ready, busy, out_data}, {4'b0101, exp});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drain"}, 132'({out_valid, in_ready, busy}), 132'(3'b010));
  endtask

  initial begin
    logic [127:0] vk [6];
    logic [127:0] vp [6];
    logic [127:0] vc [6];
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_key = '0;
    repeat (3) tick();
    chk("reset", {1'b0, out_valid, in_ready, busy, out_data}, {4'b0010, 128'h0});
    reset = 1'b0;
    tick();

    run("t1", K1, P1, C1, L1, 1'b1, 0);
    run("t2", K2, P2, C2, L2, 1'b1, 0);
    run("t3", K1, P1, C1, L1, 1'b1, 5);

    // in_valid held with a second block through the rounds and the handshake
    in_key = K1; in_data = P1; in_valid = 1'b1;
    tick();
    in_key = K2; in_data = P2;
    repeat (10) tick();
    chk("t4_first", {3'b0, out_valid, out_data}, {4'b0001, C1});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4_idle", 132'({out_valid, in_ready, busy}), 132'(3'b010));
    tick();
    chk("t4_accept", 132'({in_ready, busy}), 132'(2'b01));
    in_valid = 1'b0;
    repeat (10) tick();
    chk("t4_second", {3'b0, out_valid, out_data}, {4'b0001, C2});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset in the middle of a block
    in_key = K2; in_data = P2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_abort", {1'b0, out_valid, in_ready, busy, out_data}, {4'b0010, 128'h0});
    prev_acc = -1;
    run("t5_rerun", K2, P2, C2, L2, 1'b1, 0);

    // back-to-back known-answer vectors with random output stalls
    vk[0] = K2; vp[0] = 128'h6bc1bee22e409f96e93d7e117393172a; vc[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    vk[1] = K2; vp[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51; vc[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    vk[2] = K2; vp[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef; vc[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
    vk[3] = K2; vp[3] = 128'hf69f2445df4f9b17ad2b417be66c3710; vc[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;
    vk[4] = '0; vp[4] = '0;                                   vc[4] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    vk[5] = K1; vp[5] = P1;                                   vc[5] = C1;
    for (int j = 0; j < 12; j++)
      run("t6", vk[j%6], vp[j%6], vc[j%6], '0, 1'b0, int'($urandom_range(0, 3)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
